// File: rtl/galaxian_arb_pkg.sv
// Shared types for the Galaxian work-RAM arbiter: FSM states, hiscore op kind
// and the starvation counter width.
package galaxian_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DATA,
        ACK
    } arb_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

    localparam int unsigned STARVE_CW = 16;

    typedef logic [STARVE_CW-1:0] starve_cnt_t;

endpackage

// File: rtl/arb_starve_timer.sv
// Saturating starvation counter: counts enabled cycles unless frozen, clears on
// request and flags when the count has reached LIMIT.
module arb_starve_timer
    import galaxian_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    input  logic frz,
    output logic hit
);

    starve_cnt_t count;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !frz && (count != '1)) begin
            count <= count + starve_cnt_t'(1);
        end
    end

    assign hit = (32'(count) >= LIMIT);

endmodule

// File: rtl/galaxian_ram_arbiter.sv
// Shares the CPU work RAM between the Z80 (absolute priority, zero latency) and the
// hiscore engine, which is slotted into CPU-idle cycles outside ROM downloads.
module galaxian_ram_arbiter
    import galaxian_arb_pkg::*;
#(
    parameter int unsigned AW           = 10,
    parameter int unsigned DW           = 8,
    parameter int unsigned STARVE_LIMIT = 255
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          dn_busy,
    input  logic          cpu_sel,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    input  logic          hs_rd_req,
    input  logic          hs_wr_req,
    input  logic [AW-1:0] hs_addr,
    input  logic [DW-1:0] hs_din,
    output logic [DW-1:0] hs_dout,
    output logic          hs_ack,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          pause_req,
    output logic          busy
);

    arb_state_t state;
    arb_state_t state_nxt;
    op_t        op;
    logic       issue;
    logic       starve_clr;
    logic       starve_en;
    logic       starve_hit;

    assign issue    = (state == WAIT) && !cpu_sel && !dn_busy;
    assign cpu_dout = ram_dout;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs_rd_req || hs_wr_req) state_nxt = WAIT;
            WAIT:    if (issue) state_nxt = DATA;
            DATA:    state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Write wins when both requests are raised; the op is fixed for the whole transaction.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            op <= OP_RD;
        end else if ((state == IDLE) && (hs_rd_req || hs_wr_req)) begin
            op <= hs_wr_req ? OP_WR : OP_RD;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hs_dout <= '0;
        end else if ((state == DATA) && (op == OP_RD)) begin
            hs_dout <= ram_dout;
        end
    end

    always_comb begin
        hs_ack     = (state == ACK);
        busy       = (state != IDLE);
        starve_en  = (state == WAIT) && !issue;
        // Clearing in DATA means the count, and so pause_req, is already zero in ACK.
        starve_clr = (state == DATA);
        if (cpu_sel) begin
            ram_addr = cpu_addr;
            ram_we   = cpu_we;
            ram_din  = cpu_din;
        end else begin
            ram_addr = hs_addr;
            ram_we   = issue && (op == OP_WR);
            ram_din  = hs_din;
        end
    end

    arb_starve_timer #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .clr     (starve_clr),
        .en      (starve_en),
        .frz     (dn_busy),
        .hit     (starve_hit)
    );

    assign pause_req = starve_hit;

endmodule

// File: tb/tb_galaxian_ram_arbiter.sv
// Bench for galaxian_ram_arbiter: mux vector table, directed corner sequences and a
// randomized run, all checked against a transaction-level timing/memory model.
module tb_galaxian_ram_arbiter;

    localparam int unsigned AW  = 10;
    localparam int unsigned DW  = 8;
    localparam int unsigned LIM = 8;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          dn_busy;
    logic          cpu_sel;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic [DW-1:0] cpu_dout;
    logic          hs_rd_req;
    logic          hs_wr_req;
    logic [AW-1:0] hs_addr;
    logic [DW-1:0] hs_din;
    logic [DW-1:0] hs_dout;
    logic          hs_ack;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          pause_req;
    logic          busy;

    always #5 clk_sys = ~clk_sys;

    galaxian_ram_arbiter #(
        .AW           (AW),
        .DW           (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .dn_busy   (dn_busy),
        .cpu_sel   (cpu_sel),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .hs_rd_req (hs_rd_req),
        .hs_wr_req (hs_wr_req),
        .hs_addr   (hs_addr),
        .hs_din    (hs_din),
        .hs_dout   (hs_dout),
        .hs_ack    (hs_ack),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .pause_req (pause_req),
        .busy      (busy)
    );

    // Single-port RAM with one cycle of read latency, read-before-write.
    logic [DW-1:0] mem [1<<AW];
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // Expected RAM contents plus the timestamps of the outstanding hiscore transaction.
    logic [DW-1:0] shadow [1<<AW];
    int            total = 0;
    int            bad = 0;
    int            tcyc = 0;
    int            req_cyc;
    int            iss_cyc;
    int            blocked;
    int            n_ack = 0;
    bit            m_wr;
    bit            saw_ack;
    bit            cpu_rd_pend;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic [DW-1:0] m_rdval;
    logic [DW-1:0] m_hs_dout;
    logic [DW-1:0] cpu_rd_exp;

    typedef struct {
        logic          cs;
        logic          we;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic [AW-1:0] ha;
        logic [AW-1:0] ea;
        logic          ewe;
        logic [DW-1:0] ed;
        logic          dchk;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, tcyc);
        end
    endtask

    task automatic model_reset();
        req_cyc     = -1;
        iss_cyc     = -1;
        blocked     = 0;
        m_hs_dout   = '0;
        cpu_rd_pend = 0;
        saw_ack     = 0;
    endtask

    // Called at posedge+1 with this cycle's inputs applied; returns at the next posedge+1.
    task automatic cycle_chk();
        bit            exp_ack;
        bit            exp_pause;
        bit            exp_busy;
        bit            iss;
        bit            dchk;
        logic [AW-1:0] ea;
        logic          ewe;
        logic [DW-1:0] ed;
        #1;
        iss       = 0;
        exp_ack   = 0;
        exp_pause = 0;
        exp_busy  = (req_cyc >= 0);
        if (req_cyc >= 0) begin
            if (iss_cyc < 0) begin
                exp_pause = (blocked >= int'(LIM));
                if (!cpu_sel && !dn_busy) begin
                    iss     = 1;
                    iss_cyc = tcyc;
                end
            end else begin
                exp_ack   = (tcyc == iss_cyc + 2);
                exp_pause = (tcyc == iss_cyc + 1) && (blocked >= int'(LIM));
                if (exp_ack && !m_wr) m_hs_dout = m_rdval;
            end
        end
        if (cpu_sel) begin
            ea = cpu_addr; ewe = cpu_we; ed = cpu_din; dchk = 1;
        end else if (iss) begin
            ea = m_addr; ewe = m_wr; ed = m_din; dchk = m_wr;
        end else begin
            ea = hs_addr; ewe = 1'b0; ed = '0; dchk = 0;
        end
        chk("ram_addr", 32'(ram_addr), 32'(ea));
        chk("ram_we", 32'(ram_we), 32'(ewe));
        if (dchk) chk("ram_din", 32'(ram_din), 32'(ed));
        chk("hs_ack", 32'(hs_ack), 32'(exp_ack));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("pause_req", 32'(pause_req), 32'(exp_pause));
        chk("hs_dout", 32'(hs_dout), 32'(m_hs_dout));
        if (cpu_rd_pend) chk("cpu_dout", 32'(cpu_dout), 32'(cpu_rd_exp));

        cpu_rd_pend = cpu_sel && !cpu_we;
        cpu_rd_exp  = shadow[cpu_addr];
        if (iss && !m_wr) m_rdval = shadow[m_addr];
        if (cpu_sel && cpu_we) shadow[cpu_addr] = cpu_din;
        if (iss && m_wr) shadow[m_addr] = m_din;
        if ((req_cyc >= 0) && (iss_cyc < 0) && cpu_sel && !dn_busy) blocked++;
        if (exp_ack) begin
            req_cyc = -1;
            n_ack++;
        end else if ((req_cyc < 0) && (hs_rd_req || hs_wr_req)) begin
            req_cyc = tcyc;
            iss_cyc = -1;
            blocked = 0;
            m_wr    = hs_wr_req;
            m_addr  = hs_addr;
            m_din   = hs_din;
        end
        saw_ack = hs_ack;
        tcyc++;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_ack(input int max, output int n);
        n = 0;
        do begin
            cycle_chk();
            n++;
        end while (!saw_ack && (n < max));
        chk("ack_timeout", 32'(saw_ack), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t    vecs[6];
        int      n;
        int      k;
        int      errs;
        int      acks0;
        int      r;
        bit      seen;
        bit      outstanding;
        bit      cpu_burst;
        logic [DW-1:0] v;

        vecs[0] = '{1'b1, 1'b1, 10'h010, 8'h11, 10'h2AA, 10'h010, 1'b1, 8'h11, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 10'h020, 8'h22, 10'h2AB, 10'h020, 1'b0, 8'h22, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 10'h030, 8'h33, 10'h2AC, 10'h2AC, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 10'h000, 8'h00, 10'h3FF, 10'h3FF, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 10'h3FF, 8'hFF, 10'h000, 10'h3FF, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 10'h001, 8'h00, 10'h001, 10'h001, 1'b0, 8'h00, 1'b1};

        reset_n = 1'b0; dn_busy = 1'b0; cpu_sel = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_din = '0; hs_rd_req = 1'b0; hs_wr_req = 1'b0;
        hs_addr = '0; hs_din = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            v = DW'($urandom);
            mem[i] = v;
            shadow[i] = v;
        end
        mem[10'h123] = 8'h5A; shadow[10'h123] = 8'h5A;
        mem[10'h055] = 8'hC3; shadow[10'h055] = 8'hC3;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_hs_ack", 32'(hs_ack), 32'd0);
        chk("rst_hs_dout", 32'(hs_dout), 32'd0);
        chk("rst_pause", 32'(pause_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        cpu_sel = 1'b1; cpu_we = 1'b1;
        #1;
        chk("rst_ram_we_cpu", 32'(ram_we), 32'd1);
        cpu_sel = 1'b0; cpu_we = 1'b0;
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        @(posedge clk_sys);
        #1;

        // Combinational mux vectors with no hiscore traffic
        for (int i = 0; i < 6; i++) begin
            cpu_sel = vecs[i].cs; cpu_we = vecs[i].we; cpu_addr = vecs[i].ca;
            cpu_din = vecs[i].cd; hs_addr = vecs[i].ha;
            #1;
            chk("vec_ram_addr", 32'(ram_addr), 32'(vecs[i].ea));
            chk("vec_ram_we", 32'(ram_we), 32'(vecs[i].ewe));
            if (vecs[i].dchk) chk("vec_ram_din", 32'(ram_din), 32'(vecs[i].ed));
            cycle_chk();
        end
        cpu_sel = 1'b0; cpu_we = 1'b0;

        // Read with CPU idle
        hs_addr = 10'h123; hs_rd_req = 1'b1;
        cycle_chk();
        wait_ack(10, n);
        chk("t1_latency", 32'(n), 32'd3);
        chk("t1_hs_dout", 32'(hs_dout), 32'h5A);
        hs_rd_req = 1'b0;

        // Write held off by six CPU cycles
        hs_addr = 10'h3FF; hs_din = 8'hA5; hs_wr_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cpu_sel = 1'b1; cpu_we = i[0];
            cpu_addr = AW'(10'h100 + i); cpu_din = DW'(8'h40 + i);
            cycle_chk();
        end
        cpu_sel = 1'b0; cpu_we = 1'b0;
        wait_ack(10, n);
        chk("t2_latency", 32'(n), 32'd3);
        chk("t2_mem", 32'(mem[10'h3FF]), 32'hA5);
        hs_wr_req = 1'b0;

        // Starvation raises pause_req after LIM blocked WAIT cycles
        hs_addr = 10'h0F0; hs_rd_req = 1'b1;
        cpu_sel = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h0F1;
        cycle_chk();
        k = 0;
        while (!pause_req && (k < 50)) begin
            cycle_chk();
            k++;
        end
        chk("t3_pause_delay", 32'(k), 32'(LIM));
        cpu_sel = 1'b0;
        wait_ack(10, n);
        chk("t3_latency", 32'(n), 32'd3);
        chk("t3_pause_after", 32'(pause_req), 32'd0);
        hs_rd_req = 1'b0;

        // Download blocks the read and freezes starvation
        dn_busy = 1'b1; hs_addr = 10'h123; hs_rd_req = 1'b1; seen = 0; acks0 = n_ack;
        cycle_chk();
        for (int i = 0; i < 1000; i++) begin
            seen |= pause_req;
            cycle_chk();
        end
        chk("t4_no_pause", 32'(seen), 32'd0);
        chk("t4_no_ack", 32'(n_ack - acks0), 32'd0);
        dn_busy = 1'b0;
        wait_ack(5, n);
        chk("t4_latency", 32'(n), 32'd3);
        chk("t4_hs_dout", 32'(hs_dout), 32'h5A);
        hs_rd_req = 1'b0;

        // Simultaneous read and write: write first, read on the next transaction
        hs_addr = 10'h055; hs_din = 8'h3C; hs_rd_req = 1'b1; hs_wr_req = 1'b1;
        cycle_chk();
        wait_ack(10, n);
        chk("t5_wr_latency", 32'(n), 32'd3);
        chk("t5_mem", 32'(mem[10'h055]), 32'h3C);
        hs_wr_req = 1'b0;
        wait_ack(10, n);
        chk("t5_rd_latency", 32'(n), 32'd4);
        chk("t5_hs_dout", 32'(hs_dout), 32'h3C);
        hs_rd_req = 1'b0;

        // Request dropped while waiting still completes
        hs_addr = 10'h200; hs_rd_req = 1'b1; cpu_sel = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h201;
        cycle_chk();
        cycle_chk();
        hs_rd_req = 1'b0;
        cycle_chk();
        cpu_sel = 1'b0;
        wait_ack(10, n);
        chk("drop_latency", 32'(n), 32'd3);

        // Reset during DATA
        hs_addr = 10'h2C0; hs_rd_req = 1'b1;
        cycle_chk();
        cycle_chk();
        reset_n = 1'b0;
        #1;
        chk("t6_hs_ack", 32'(hs_ack), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_pause", 32'(pause_req), 32'd0);
        chk("t6_hs_dout", 32'(hs_dout), 32'd0);
        chk("t6_ram_we", 32'(ram_we), 32'd0);
        hs_rd_req = 1'b0;
        @(posedge clk_sys);
        #1;
        chk("t6_ack_in_reset", 32'(hs_ack), 32'd0);
        reset_n = 1'b1;
        model_reset();
        repeat (5) cycle_chk();
        errs = 0;
        for (int i = 0; i < (1 << AW); i++) if (mem[i] !== shadow[i]) errs++;
        chk("t6_ram_intact", 32'(errs), 32'd0);

        // Randomized traffic
        outstanding = 0; cpu_burst = 0; acks0 = n_ack;
        for (int c = 0; c < 4000; c++) begin
            if (outstanding && saw_ack) begin
                hs_rd_req = 1'b0; hs_wr_req = 1'b0; outstanding = 0;
            end else if (!outstanding && ($urandom_range(3) == 0)) begin
                r = int'($urandom_range(2));
                hs_rd_req = (r != 1); hs_wr_req = (r != 0);
                hs_addr = AW'($urandom); hs_din = DW'($urandom);
                outstanding = 1;
            end
            if ($urandom_range(15) == 0) cpu_burst = !cpu_burst;
            cpu_sel  = cpu_burst || ($urandom_range(3) == 0);
            cpu_we   = 1'($urandom_range(1));
            cpu_addr = AW'($urandom);
            cpu_din  = DW'($urandom);
            if (dn_busy ? ($urandom_range(7) == 0) : ($urandom_range(63) == 0)) dn_busy = !dn_busy;
            cycle_chk();
        end
        chk("rand_progress", 32'((n_ack - acks0) > 50), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
